// File: rtl/cafeteira_serial_tx.sv
// Coffee-machine status reporter: sends "P"/"G"/"E" + CR + LF over UART 8N1.
// Ports: clock, reset (sync, active-high), enviar/evento request in,
//        txd serial out (idle high), ocupado busy flag, fim done pulse.
module cafeteira_serial_tx #(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enviar,
   input  logic [1:0] evento,
   output logic       txd,
   output logic       ocupado,
   output logic       fim
);

   localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t        state, state_n;
   logic [TW-1:0] timer, timer_n;
   logic [2:0]    bit_idx, bit_idx_n;
   logic [1:0]    byte_idx, byte_idx_n;
   logic [1:0]    code, code_n;
   logic          txd_n, ocupado_n, fim_n;
   logic [7:0]    code_char, cur_byte;
   logic [2:0]    bit_nxt;
   logic          last;

   always_comb begin
      unique case (code)
         2'b01:   code_char = 8'h50;
         2'b10:   code_char = 8'h47;
         2'b11:   code_char = 8'h45;
         default: code_char = 8'h00;
      endcase
      unique case (byte_idx)
         2'd0:    cur_byte = code_char;
         2'd1:    cur_byte = 8'h0D;
         default: cur_byte = 8'h0A;
      endcase
   end

   assign last    = (timer == LAST);
   assign bit_nxt = bit_idx + 3'd1;

   // Next-state logic. txd is registered, so each branch that crosses a
   // bit boundary also loads the value of the bit being entered.
   always_comb begin
      state_n    = state;
      timer_n    = timer + TW'(1);
      bit_idx_n  = bit_idx;
      byte_idx_n = byte_idx;
      code_n     = code;
      txd_n      = txd;
      ocupado_n  = ocupado;
      fim_n      = 1'b0;
      unique case (state)
         IDLE: begin
            timer_n   = '0;
            txd_n     = 1'b1;
            ocupado_n = 1'b0;
            if (enviar && (evento != 2'b00)) begin
               state_n    = START;
               code_n     = evento;
               bit_idx_n  = '0;
               byte_idx_n = '0;
               txd_n      = 1'b0;
               ocupado_n  = 1'b1;
            end
         end
         START: begin
            if (last) begin
               state_n   = DATA;
               timer_n   = '0;
               bit_idx_n = '0;
               txd_n     = cur_byte[0];
            end
         end
         DATA: begin
            if (last) begin
               timer_n = '0;
               if (bit_idx == 3'd7) begin
                  state_n = STOP;
                  txd_n   = 1'b1;
               end else begin
                  bit_idx_n = bit_nxt;
                  txd_n     = cur_byte[bit_nxt];
               end
            end
         end
         STOP: begin
            if (last) begin
               timer_n = '0;
               if (byte_idx == 2'd2) begin
                  state_n    = IDLE;
                  byte_idx_n = '0;
                  code_n     = '0;
                  txd_n      = 1'b1;
                  ocupado_n  = 1'b0;
                  fim_n      = 1'b1;
               end else begin
                  state_n    = START;
                  byte_idx_n = byte_idx + 2'd1;
                  txd_n      = 1'b0;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         timer    <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         code     <= '0;
         txd      <= 1'b1;
         ocupado  <= 1'b0;
         fim      <= 1'b0;
      end else begin
         state    <= state_n;
         timer    <= timer_n;
         bit_idx  <= bit_idx_n;
         byte_idx <= byte_idx_n;
         code     <= code_n;
         txd      <= txd_n;
         ocupado  <= ocupado_n;
         fim      <= fim_n;
      end
   end

endmodule

// File: tb/tb_cafeteira_serial_tx.sv
// Directed bench for cafeteira_serial_tx at CLKS_PER_BIT=4.
// Checks frame bits, busy/done timing, ignore rules, reset abort, loopback.
module tb_cafeteira_serial_tx;

   localparam int CPB = 4;

   logic       clock = 1'b0;
   logic       reset;
   logic       enviar;
   logic [1:0] evento;
   logic       txd;
   logic       ocupado;
   logic       fim;

   int errors = 0;
   int checks = 0;
   int busy_total = 0;

   logic [7:0] rx_q[$];
   bit         rx_en = 1'b0;

   always #5 clock = ~clock;

   cafeteira_serial_tx #(.CLKS_PER_BIT(CPB)) dut (
      .clock   (clock),
      .reset   (reset),
      .enviar  (enviar),
      .evento  (evento),
      .txd     (txd),
      .ocupado (ocupado),
      .fim     (fim)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic accept(input logic [1:0] ev);
      enviar = 1'b1;
      evento = ev;
      tick();
      enviar = 1'b0;
   endtask

   function automatic logic fbit(input logic [7:0] b, input int i);
      if (i == 0) return 1'b0;
      if (i == 9) return 1'b1;
      return b[i-1];
   endfunction

   // Called #1 after the accepting edge; follows the 120-cycle message.
   task automatic watch_msg(input string tag, input logic [7:0] c,
                            input int inject_at, input bit chain);
      logic [7:0] m[3];
      logic [7:0] dec[3];
      int bad, busy, fims, j;
      m = '{c, 8'h0D, 8'h0A};
      dec = '{8'h00, 8'h00, 8'h00};
      bad = 0;
      busy = 0;
      fims = 0;
      for (int k = 0; k < 30 * CPB; k++) begin
         if (k == inject_at) begin
            enviar = 1'b1;
            evento = 2'b11;
         end else if (k == inject_at + 1) begin
            enviar = 1'b0;
         end
         j = k / CPB;
         if (txd !== fbit(m[j/10], j % 10)) bad++;
         if ((k % CPB == 2) && (j % 10 >= 1) && (j % 10 <= 8))
            dec[j/10][j%10-1] = txd;
         if (ocupado) busy++;
         if (fim) fims++;
         tick();
      end
      check({tag, "_stream_bad"}, bad, 0);
      check({tag, "_busy"}, busy, 30 * CPB);
      check({tag, "_early_fim"}, fims, 0);
      check({tag, "_byte0"}, dec[0], c);
      check({tag, "_byte1"}, dec[1], 8'h0D);
      check({tag, "_byte2"}, dec[2], 8'h0A);
      check({tag, "_fim"}, fim, 1);
      check({tag, "_end_busy"}, ocupado, 0);
      check({tag, "_end_txd"}, txd, 1);
      busy_total += busy;
      if (chain) begin
         enviar = 1'b1;
         evento = 2'b01;
         tick();
         enviar = 1'b0;
         check({tag, "_chain_busy"}, ocupado, 1);
         check({tag, "_chain_start"}, txd, 0);
      end else begin
         tick();
         check({tag, "_fim_once"}, fim, 0);
         check({tag, "_idle_busy"}, ocupado, 0);
      end
   endtask

   // Loopback receiver: starts on a low line, confirms mid-start,
   // samples each bit mid-cell, keeps bytes with a valid stop bit.
   initial begin : rx_proc
      logic [7:0] b;
      b = 8'h00;
      forever begin
         @(negedge clock);
         if (rx_en && txd === 1'b0) begin
            @(negedge clock);
            if (txd === 1'b0) begin
               for (int i = 0; i < 8; i++) begin
                  repeat (CPB) @(negedge clock);
                  b[i] = txd;
               end
               repeat (CPB) @(negedge clock);
               if (txd === 1'b1) rx_q.push_back(b);
            end
         end
      end
   end

   initial begin : main
      int bad_tx, bad_busy, bad_fim;
      reset  = 1'b1;
      enviar = 1'b0;
      evento = 2'b00;
      repeat (3) tick();
      check("rst_txd", txd, 1);
      check("rst_busy", ocupado, 0);
      check("rst_fim", fim, 0);

      enviar = 1'b1;
      evento = 2'b01;
      tick();
      enviar = 1'b0;
      check("rst_prio_busy", ocupado, 0);
      check("rst_prio_txd", txd, 1);
      reset = 1'b0;
      tick();

      accept(2'b01);
      watch_msg("P", 8'h50, -1, 1'b0);

      accept(2'b00);
      bad_tx = 0;
      bad_busy = 0;
      bad_fim = 0;
      for (int k = 0; k < 200; k++) begin
         if (txd !== 1'b1) bad_tx++;
         if (ocupado !== 1'b0) bad_busy++;
         if (fim !== 1'b0) bad_fim++;
         tick();
      end
      check("inv_txd", bad_tx, 0);
      check("inv_busy", bad_busy, 0);
      check("inv_fim", bad_fim, 0);

      accept(2'b10);
      watch_msg("G", 8'h47, 10, 1'b0);

      accept(2'b11);
      repeat (50) tick();
      reset = 1'b1;
      tick();
      check("abort_txd", txd, 1);
      check("abort_busy", ocupado, 0);
      reset = 1'b0;
      bad_tx = 0;
      bad_busy = 0;
      bad_fim = 0;
      for (int k = 0; k < 150; k++) begin
         if (txd !== 1'b1) bad_tx++;
         if (ocupado !== 1'b0) bad_busy++;
         if (fim !== 1'b0) bad_fim++;
         tick();
      end
      check("abort_idle_txd", bad_tx, 0);
      check("abort_idle_busy", bad_busy, 0);
      check("abort_no_fim", bad_fim, 0);
      accept(2'b01);
      watch_msg("P_after_abort", 8'h50, -1, 1'b0);

      busy_total = 0;
      accept(2'b01);
      watch_msg("B2B_1", 8'h50, -1, 1'b1);
      watch_msg("B2B_2", 8'h50, -1, 1'b0);
      check("b2b_total_busy", busy_total, 60 * CPB);

      rx_q.delete();
      rx_en = 1'b1;
      accept(2'b11);
      watch_msg("E", 8'h45, -1, 1'b0);
      rx_en = 1'b0;
      check("rx_count", rx_q.size(), 3);
      if (rx_q.size() >= 3) begin
         check("rx_byte0", rx_q[0], 8'h45);
         check("rx_byte1", rx_q[1], 8'h0D);
         check("rx_byte2", rx_q[2], 8'h0A);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cafeteira_serial_tx.md
CAFETEIRA_SERIAL_TX -- requirements
Module: cafeteira_serial_tx

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, default 5208, clock cycles per UART bit (9600 baud at 50 MHz); legal range 2..65535.
REQ-002 SHALL have port: clock  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: enviar  input  1  one-cycle send request, sampled in IDLE only.
REQ-005 SHALL have port: evento  input  2  status code, sampled with enviar: 01 small coffee done, 10 large coffee done, 11 error, 00 invalid.
REQ-006 SHALL have port: txd  output  1  UART serial output, 8N1, LSB first, idle high.
REQ-007 SHALL have port: ocupado  output  1  high while a message is being transmitted.
REQ-008 SHALL have port: fim  output  1  one-cycle pulse when a message completes.

Function
REQ-009 SHALL transmit a 3-byte ASCII message per accepted request: code byte, then 0x0D, then 0x0A.
REQ-010 SHALL map code byte: evento 01 -> "P" (0x50), 10 -> "G" (0x47), 11 -> "E" (0x45).
REQ-011 SHALL ignore enviar when evento = 00: no transmission, ocupado and fim stay low.
REQ-012 SHALL ignore enviar while ocupado = 1; no queuing; the in-flight message is unaffected.
REQ-013 SHALL latch evento at acceptance; later changes to evento do not alter the in-flight message.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-015 SHALL transition IDLE -> START on the edge that samples a valid request; ocupado and txd=0 are visible from that edge.
REQ-016 SHALL hold each bit (start, 8 data, stop) for exactly CLKS_PER_BIT cycles, using one bit-timer counter that restarts at every bit boundary.
REQ-017 SHALL order frame bits: start=0, data bit0..bit7, stop=1; one frame is 10*CLKS_PER_BIT cycles.
REQ-018 SHALL chain frames: at the end of a non-final STOP, go directly to START of the next byte with no idle gap.
REQ-019 SHALL, at the end of the third byte's STOP, return to IDLE, drive ocupado=0, and pulse fim=1 for exactly one cycle on that same edge.
REQ-020 SHALL make a full message last exactly 30*CLKS_PER_BIT cycles, from the edge where ocupado rises to the edge where fim pulses.
REQ-021 SHALL accept a new enviar in the cycle fim is high (state IDLE), giving back-to-back messages with no gap.
REQ-022 SHALL drive txd from a register; txd=1 whenever in IDLE.
REQ-023 SHALL size the bit-timer counter for CLKS_PER_BIT-1, with a 3-bit data-bit index and a 2-bit byte index; no counter wraps silently mid-frame.

Reset
REQ-024 SHALL, with reset=1 at a clock edge, set state=IDLE, txd=1, ocupado=0, fim=0, and clear all counters and the latched code.
REQ-025 SHALL abort any in-progress message on reset: txd=1 on the next edge, no fim pulse, and no resumption after reset.
REQ-026 SHALL give reset priority over enviar in the same cycle.

Verification (CLKS_PER_BIT=4)
REQ-027 SHALL test: reset, then enviar=1 with evento=01 for 1 cycle -> txd carries frames 0x50, 0x0D, 0x0A (each 40 cycles, LSB first); ocupado high for 120 cycles; fim pulses once on cycle 120.
REQ-028 SHALL test: enviar with evento=00 -> txd stays 1, ocupado=0, fim=0 for 200 cycles.
REQ-029 SHALL test: evento=10 accepted, then at cycle 10 enviar with evento=11 and evento changed -> only "G",CR,LF sent; single fim pulse.
REQ-030 SHALL test: evento=11 accepted, reset asserted at cycle 50 -> txd=1 and ocupado=0 the next cycle; no fim; a following evento=01 request sends a correct "P" message.
REQ-031 SHALL test: enviar with evento=01 asserted in the fim cycle -> the second message's start bit begins immediately, with no idle gap (240 cycles total for two messages).
REQ-032 SHALL test: loop back txd into the team's UART receiver (same CLKS_PER_BIT) -> the receiver decodes bytes 0x45, 0x0D, 0x0A in order.
